config_mem_loader: RTL and testbench

Writer side of the neuron configuration memories. Receives configuration packets on a 32-bit valid/ready stream from the NoC/host loader and decodes a header. Assembles multi-beat entries and issues single-cycle write strobes, with address and data, to the write ports of config memories A (STDP/learning), B (neuron type/threshold/AER) and C (per-synapse learn mode). Used to program or reprogram a core at runtime without MIF/file initialisation.

---
 rtl/config_mem_loader.sv | 199 +++++++++++++++++++
 tb/tb_config_mem_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/config_mem_loader.sv
// config_mem_loader: decodes config packets and issues write strobes to config memories A/B/C.
// Optional CFG_CHECKSUM_EN adds an XOR trailer beat per packet, checked into err_o[1].
module config_mem_loader #(
    parameter int NUM_NURNS          = 256,
    parameter int NUM_AXONS          = 256,
    parameter int DSIZE              = 16,
    parameter int NURN_CNT_BIT_WIDTH = 8,
    parameter int AXON_CNT_BIT_WIDTH = 8,
    parameter int STDP_WIN_BIT_WIDTH = 8,
    parameter int AER_BIT_WIDTH      = 32,
    parameter int MEM_WIDTH_A        = 2*STDP_WIN_BIT_WIDTH+2*DSIZE+1,
    parameter int MEM_WIDTH_B        = 2+2*DSIZE+AER_BIT_WIDTH,
    parameter int MEM_WIDTH_C        = 1
) (
    input  logic                                         clk_i,
    input  logic                                         rst_n_i,
    input  logic [31:0]                                  cfg_data_i,
    input  logic                                         cfg_valid_i,
    output logic                                         cfg_ready_o,
    output logic                                         wrEn_A_o,
    output logic [NURN_CNT_BIT_WIDTH-1:0]                wrAddr_A_o,
    output logic [MEM_WIDTH_A-1:0]                       wrData_A_o,
    output logic                                         wrEn_B_o,
    output logic [NURN_CNT_BIT_WIDTH-1:0]                wrAddr_B_o,
    output logic [MEM_WIDTH_B-1:0]                       wrData_B_o,
    output logic                                         wrEn_C_o,
    output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] wrAddr_C_o,
    output logic [MEM_WIDTH_C-1:0]                       wrData_C_o,
    output logic                                         load_done_o,
    output logic [1:0]                                   err_o,
    input  logic                                         err_clr_i
);
    localparam int NW = NURN_CNT_BIT_WIDTH;
    localparam int AW = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;

    typedef enum logic [1:0] {S_HDR, S_PLD, S_DISC, S_TRL} state_t;
`ifdef CFG_CHECKSUM_EN
    localparam state_t S_END = S_TRL;
`else
    localparam state_t S_END = S_HDR;
`endif

    state_t state_q, state_d;
    logic [1:0] sel_q, sel_d, beat_q, beat_d, err_q, err_d, beat_max;
    logic [7:0] len_q, len_d, cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic [63:0] entry_q, entry_d;
    logic [MEM_WIDTH_B-1:0] wr_data_q, wr_data_d;
    logic wr_a_q, wr_a_d, wr_b_q, wr_b_d, wr_c_q, wr_c_d, load_done_q, load_done_d;
    logic acc, last_beat, last_ent;
    logic [NW-1:0] na_inc;
`ifdef CFG_CHECKSUM_EN
    logic [31:0] csum_q, csum_d;
`endif

    assign cfg_ready_o = rst_n_i;
    assign acc         = cfg_valid_i & cfg_ready_o;
    // last beat index within an entry: A=2 beats, B=3, C=1
    assign beat_max    = sel_q == 2'd0 ? 2'd1 : sel_q == 2'd1 ? 2'd2 : 2'd0;
    assign last_beat   = beat_q == beat_max;
    assign last_ent    = cnt_q == len_q;
    assign na_inc      = addr_q[NW-1:0] + 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_HDR;
            sel_q       <= '0;
            beat_q      <= '0;
            err_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wr_addr_q   <= '0;
            entry_q     <= '0;
            wr_data_q   <= '0;
            wr_a_q      <= 1'b0;
            wr_b_q      <= 1'b0;
            wr_c_q      <= 1'b0;
            load_done_q <= 1'b0;
`ifdef CFG_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wr_addr_q   <= wr_addr_d;
            entry_q     <= entry_d;
            wr_data_q   <= wr_data_d;
            wr_a_q      <= wr_a_d;
            wr_b_q      <= wr_b_d;
            wr_c_q      <= wr_c_d;
            load_done_q <= load_done_d;
`ifdef CFG_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (acc) begin
            case (state_q)
                S_HDR:   state_d = cfg_data_i[31:30] == 2'd3 ? S_DISC : S_PLD;
                S_PLD:   state_d = last_beat && last_ent ? S_END : S_PLD;
                S_DISC:  state_d = last_ent ? S_END : S_DISC;
                default: state_d = S_HDR;
            endcase
        end
    end

    always_comb begin
        sel_d       = sel_q;
        beat_d      = beat_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wr_addr_d   = wr_addr_q;
        entry_d     = entry_q;
        wr_data_d   = wr_data_q;
        wr_a_d      = 1'b0;
        wr_b_d      = 1'b0;
        wr_c_d      = 1'b0;
        load_done_d = 1'b0;
        // a new error in the same cycle as err_clr_i overrides the clear
        err_d       = err_clr_i ? 2'b00 : err_q;
`ifdef CFG_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        if (acc) begin
            case (state_q)
                S_HDR: begin
                    sel_d    = cfg_data_i[31:30];
                    len_d    = cfg_data_i[23:16];
                    addr_d   = cfg_data_i[31:30] == 2'd2 ? cfg_data_i[AW-1:0] : AW'(cfg_data_i[NW-1:0]);
                    cnt_d    = '0;
                    beat_d   = '0;
                    err_d[0] = err_d[0] | (cfg_data_i[31:30] == 2'd3);
`ifdef CFG_CHECKSUM_EN
                    csum_d   = cfg_data_i;
`endif
                end
                S_PLD: begin
`ifdef CFG_CHECKSUM_EN
                    csum_d = csum_q ^ cfg_data_i;
`endif
                    if (last_beat) begin
                        wr_a_d    = sel_q == 2'd0;
                        wr_b_d    = sel_q == 2'd1;
                        wr_c_d    = sel_q == 2'd2;
                        wr_addr_d = addr_q;
                        wr_data_d = sel_q == 2'd0 ? MEM_WIDTH_B'({cfg_data_i[MEM_WIDTH_A-33:0], entry_q[31:0]}) :
                                    sel_q == 2'd1 ? {cfg_data_i[MEM_WIDTH_B-65:0], entry_q} :
                                                    MEM_WIDTH_B'(cfg_data_i[0]);
                        addr_d    = sel_q == 2'd2 ? addr_q + 1'b1 : AW'(na_inc);
                        cnt_d     = cnt_q + 1'b1;
                        beat_d    = '0;
`ifndef CFG_CHECKSUM_EN
                        load_done_d = last_ent;
`endif
                    end else begin
                        beat_d  = beat_q + 1'b1;
                        entry_d = beat_q[0] ? {cfg_data_i, entry_q[31:0]} : {entry_q[63:32], cfg_data_i};
                    end
                end
                S_DISC: begin
                    cnt_d = cnt_q + 1'b1;
`ifdef CFG_CHECKSUM_EN
                    csum_d = csum_q ^ cfg_data_i;
`else
                    load_done_d = last_ent;
`endif
                end
                default: begin
`ifdef CFG_CHECKSUM_EN
                    load_done_d = 1'b1;
                    err_d[1]    = err_d[1] | (cfg_data_i != csum_q);
`endif
                end
            endcase
        end
    end

    assign wrEn_A_o    = wr_a_q;
    assign wrEn_B_o    = wr_b_q;
    assign wrEn_C_o    = wr_c_q;
    assign wrAddr_A_o  = wr_addr_q[NW-1:0];
    assign wrAddr_B_o  = wr_addr_q[NW-1:0];
    assign wrAddr_C_o  = wr_addr_q;
    assign wrData_A_o  = wr_data_q[MEM_WIDTH_A-1:0];
    assign wrData_B_o  = wr_data_q;
    assign wrData_C_o  = wr_data_q[MEM_WIDTH_C-1:0];
    assign load_done_o = load_done_q;
    assign err_o       = err_q;
endmodule

// File: tb/tb_config_mem_loader.sv
// tb_config_mem_loader: directed vector table for config_mem_loader, plus reset sequences.
module tb_config_mem_loader;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [31:0] cfg_data_i = '0;
    logic        cfg_valid_i = 1'b0;
    logic        err_clr_i = 1'b0;
    logic        cfg_ready_o, wrEn_A_o, wrEn_B_o, wrEn_C_o, load_done_o;
    logic [7:0]  wrAddr_A_o, wrAddr_B_o;
    logic [15:0] wrAddr_C_o;
    logic [48:0] wrData_A_o;
    logic [65:0] wrData_B_o;
    logic [0:0]  wrData_C_o;
    logic [1:0]  err_o;

    config_mem_loader dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .cfg_data_i(cfg_data_i), .cfg_valid_i(cfg_valid_i),
        .cfg_ready_o(cfg_ready_o), .wrEn_A_o(wrEn_A_o), .wrAddr_A_o(wrAddr_A_o), .wrData_A_o(wrData_A_o),
        .wrEn_B_o(wrEn_B_o), .wrAddr_B_o(wrAddr_B_o), .wrData_B_o(wrData_B_o),
        .wrEn_C_o(wrEn_C_o), .wrAddr_C_o(wrAddr_C_o), .wrData_C_o(wrData_C_o),
        .load_done_o(load_done_o), .err_o(err_o), .err_clr_i(err_clr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] d;
        logic        v;
        logic        clr;
        logic        rst;
        logic [2:0]  we;
        logic [15:0] addr;
        logic [65:0] data;
        logic        done;
        logic [1:0]  err;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] csum;
    int checks = 0;
    int fails = 0;

`ifdef CFG_CHECKSUM_EN
    localparam logic DW = 1'b0;
`else
    localparam logic DW = 1'b1;
`endif

    function automatic void add(logic [31:0] d, logic v, logic clr, logic rst, logic [2:0] we,
                                logic [15:0] a, logic [65:0] dat, logic dn, logic [1:0] e);
        vec_t x;
        x.d = d; x.v = v; x.clr = clr; x.rst = rst; x.we = we;
        x.addr = a; x.data = dat; x.done = dn; x.err = e;
        vecs.push_back(x);
    endfunction

    function automatic void hdr(logic [31:0] d, logic clr, logic [1:0] e);
        csum = d;
        add(d, 1'b1, clr, 1'b0, 3'b000, '0, '0, 1'b0, e);
    endfunction

    function automatic void beat(logic [31:0] d, logic [2:0] we, logic [15:0] a, logic [65:0] dat,
                                 logic dn, logic [1:0] e);
        csum = csum ^ d;
        add(d, 1'b1, 1'b0, 1'b0, we, a, dat, dn, e);
    endfunction

    function automatic void idle(logic clr, logic [1:0] e);
        add(32'hFFFF_FFFF, 1'b0, clr, 1'b0, 3'b000, '0, '0, 1'b0, e);
    endfunction

    function automatic void trailer(logic good, logic [1:0] e);
`ifdef CFG_CHECKSUM_EN
        add(good ? csum : ~csum, 1'b1, 1'b0, 1'b0, 3'b000, '0, '0, 1'b1, e);
`else
        if (good && e == 2'b11) csum = csum;
`endif
    endfunction

    initial begin
        logic [2:0]  we;
        logic [15:0] aa;
        logic [65:0] ad;
        logic        ok;
        // A: two entries, second write carries load_done
        hdr(32'h0001_0005, 1'b0, 2'b00);
        beat(32'h89AB_CDEF, 3'b000, 16'h0, 66'h0, 1'b0, 2'b00);
        beat(32'h0000_1234, 3'b100, 16'h0005, 66'h1234_89AB_CDEF, 1'b0, 2'b00);
        beat(32'h1111_1111, 3'b000, 16'h0, 66'h0, 1'b0, 2'b00);
        beat(32'h0000_0001, 3'b100, 16'h0006, 66'h1_1111_1111, DW, 2'b00);
        trailer(1'b1, 2'b00);
        // B with valid gaps inside the entry
        hdr(32'h4000_00FE, 1'b0, 2'b00);
        idle(1'b0, 2'b00);
        beat(32'hDEAD_BEEF, 3'b000, 16'h0, 66'h0, 1'b0, 2'b00);
        idle(1'b0, 2'b00);
        idle(1'b0, 2'b00);
        beat(32'h0000_FFFF, 3'b000, 16'h0, 66'h0, 1'b0, 2'b00);
        idle(1'b0, 2'b00);
        beat(32'h0000_0003, 3'b010, 16'h00FE, 66'h3_0000_FFFF_DEAD_BEEF, DW, 2'b00);
        trailer(1'b1, 2'b00);
        // C address wrap, back-to-back strobes
        hdr(32'h8001_FFFF, 1'b0, 2'b00);
        beat(32'h0000_0001, 3'b001, 16'hFFFF, 66'h1, 1'b0, 2'b00);
        beat(32'h0000_0000, 3'b001, 16'h0000, 66'h0, DW, 2'b00);
        trailer(1'b1, 2'b00);
        // A: ignored header bits, truncated address wrapping 0xFF->0x00, excess data bits dropped
        hdr(32'h3F01_01FF, 1'b0, 2'b00);
        beat(32'hFFFF_FFFF, 3'b000, 16'h0, 66'h0, 1'b0, 2'b00);
        beat(32'hFFFF_FFFF, 3'b100, 16'h00FF, 66'h1_FFFF_FFFF_FFFF, 1'b0, 2'b00);
        beat(32'h0000_0000, 3'b000, 16'h0, 66'h0, 1'b0, 2'b00);
        beat(32'h0000_0000, 3'b100, 16'h0000, 66'h0, DW, 2'b00);
        trailer(1'b1, 2'b00);
        // bad select: discard, sticky error, clear
        hdr(32'hC002_0000, 1'b0, 2'b01);
        beat(32'h0000_0005, 3'b000, 16'h0, 66'h0, 1'b0, 2'b01);
        beat(32'h0000_0006, 3'b000, 16'h0, 66'h0, 1'b0, 2'b01);
        beat(32'h0000_0007, 3'b000, 16'h0, 66'h0, DW, 2'b01);
        trailer(1'b1, 2'b01);
        idle(1'b1, 2'b00);
        // clear and new error in the same cycle: set wins
        hdr(32'hC000_0000, 1'b1, 2'b01);
        beat(32'h0000_0009, 3'b000, 16'h0, 66'h0, DW, 2'b01);
        trailer(1'b1, 2'b01);
        idle(1'b1, 2'b00);
        // reset after the second B beat, then a fresh C header
        hdr(32'h4000_0020, 1'b0, 2'b00);
        beat(32'h0000_0001, 3'b000, 16'h0, 66'h0, 1'b0, 2'b00);
        beat(32'h0000_0002, 3'b000, 16'h0, 66'h0, 1'b0, 2'b00);
        add(32'h0000_0003, 1'b1, 1'b0, 1'b1, 3'b000, '0, '0, 1'b0, 2'b00);
        idle(1'b0, 2'b00);
        hdr(32'h8000_0007, 1'b0, 2'b00);
        beat(32'h0000_0001, 3'b001, 16'h0007, 66'h1, DW, 2'b00);
        trailer(1'b1, 2'b00);
`ifdef CFG_CHECKSUM_EN
        // wrong trailer: write still lands, err_o[1] set
        hdr(32'h0000_0010, 1'b0, 2'b00);
        beat(32'h0000_000A, 3'b000, 16'h0, 66'h0, 1'b0, 2'b00);
        beat(32'h0000_000B, 3'b100, 16'h0010, 66'h0_0000_000B_0000_000A, 1'b0, 2'b00);
        trailer(1'b0, 2'b10);
        idle(1'b1, 2'b00);
`endif

        // held in reset: everything quiet and not ready
        rst_n_i = 1'b0;
        cfg_valid_i = 1'b1;
        cfg_data_i = 32'h0001_0005;
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({cfg_ready_o, wrEn_A_o, wrEn_B_o, wrEn_C_o, load_done_o, err_o} != 7'd0 ||
            wrAddr_C_o != 16'd0 || wrData_B_o != 66'd0) begin
            fails++;
            $display("FAIL reset_state: ready=%b we=%b%b%b done=%b err=%b addr=%h data=%h, required all zero",
                     cfg_ready_o, wrEn_A_o, wrEn_B_o, wrEn_C_o, load_done_o, err_o, wrAddr_C_o, wrData_B_o);
        end
        @(negedge clk_i);
        rst_n_i = 1'b1;
        cfg_valid_i = 1'b0;
        #1;
        checks++;
        if (cfg_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL ready_after_reset: got %b, required 1", cfg_ready_o);
        end

        foreach (vecs[i]) begin
            @(negedge clk_i);
            cfg_data_i  = vecs[i].d;
            cfg_valid_i = vecs[i].v;
            err_clr_i   = vecs[i].clr;
            rst_n_i     = ~vecs[i].rst;
            @(posedge clk_i);
            #1;
            we = {wrEn_A_o, wrEn_B_o, wrEn_C_o};
            aa = vecs[i].we[2] ? {8'h00, wrAddr_A_o} : vecs[i].we[1] ? {8'h00, wrAddr_B_o} : wrAddr_C_o;
            ad = vecs[i].we[2] ? {17'h0, wrData_A_o} : vecs[i].we[1] ? wrData_B_o : {65'h0, wrData_C_o};
            ok = we === vecs[i].we && load_done_o === vecs[i].done && err_o === vecs[i].err &&
                 cfg_ready_o === ~vecs[i].rst && (vecs[i].we == 3'b000 || (aa === vecs[i].addr && ad === vecs[i].data));
            checks++;
            if (!ok) begin
                fails++;
                $display("FAIL row%0d: got we=%b addr=%h data=%h done=%b err=%b ready=%b, required we=%b addr=%h data=%h done=%b err=%b ready=%b",
                         i, we, aa, ad, load_done_o, err_o, cfg_ready_o,
                         vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].done, vecs[i].err, ~vecs[i].rst);
            end
        end

        // quiet after the last packet: no stray strobes
        @(negedge clk_i);
        cfg_valid_i = 1'b0;
        err_clr_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({wrEn_A_o, wrEn_B_o, wrEn_C_o, load_done_o} != 4'd0) begin
            fails++;
            $display("FAIL idle_quiet: we=%b%b%b done=%b, required 0000", wrEn_A_o, wrEn_B_o, wrEn_C_o, load_done_o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
